// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult8_seq_ctrl
// Purpose  : Sequential 8x8 unsigned shift-and-add multiplier controller that
//            drives an external shared 8-bit adder, one partial add per clock.
// Revision : 1.0 - initial release
// ============================================================================
module mult8_seq_ctrl #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_start,
    input  logic [N_BITS-1:0]     i_multiplicand,
    input  logic [N_BITS-1:0]     i_multiplier,
    output logic [N_BITS-1:0]     o_add_a,
    output logic [N_BITS-1:0]     o_add_b,
    input  logic [N_BITS-1:0]     i_add_sum,
    input  logic                  i_add_cout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2*N_BITS-1:0]   o_product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [N_BITS-1:0]   r_a;
    logic [N_BITS-1:0]   r_q;
    logic [N_BITS-1:0]   r_m;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*N_BITS-1:0] r_product;

    logic                w_load;
    logic                w_run;
    logic                w_last;
    logic [2*N_BITS-1:0] w_shift;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_cnt == CNT_W'(N_BITS - 1));
    // Carry lands in A's MSB; the sum's LSB moves into Q as Q[0] retires.
    assign w_shift = {i_add_cout, i_add_sum, r_q[N_BITS-1:1]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_a   <= '0;
            r_q   <= i_multiplier;
            r_m   <= i_multiplicand;
            r_cnt <= '0;
        end else if (w_run) begin
            {r_a, r_q} <= w_shift;
            r_cnt      <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_product <= w_shift;
            end
        end
    end

    // The shared adder sees zeros whenever the controller is not iterating.
    assign o_add_a   = w_run ? r_a : '0;
    assign o_add_b   = (w_run && r_q[0]) ? r_m : '0;
    assign o_busy    = w_run;
    assign o_done    = (r_state == S_DONE);
    assign o_product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult8_seq_ctrl
// Purpose  : Self-checking bench for mult8_seq_ctrl with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  mcand = 8'h00;
    logic [7:0]  mplier = 8'h00;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_product = 16'h0000;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared 8-bit full adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    mult8_seq_ctrl #(.N_BITS(8), .CNT_W(3)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .i_start        (start),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .o_add_a        (add_a),
        .o_add_b        (add_b),
        .i_add_sum      (add_sum),
        .i_add_cout     (add_cout),
        .o_busy         (busy),
        .o_done         (done),
        .o_product      (product)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full multiplication starting from IDLE or DONE; the model for the
    // accumulator is the partial product of the low i multiplier bits >> i.
    task automatic run_one(input logic [7:0] m, input logic [7:0] q,
                           input bit hold, input string tag);
        int unsigned exp_a;
        logic [7:0]  exp_b;
        start  = 1'b1;
        mcand  = m;
        mplier = q;
        for (int i = 0; i < 8; i++) begin
            step();
            if (hold) begin
                mcand  = 8'($urandom);
                mplier = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL %s run%0d busy/done got %b/%b want 1/0", tag, i, busy, done);
            end
            exp_a = (int'(m) * (int'(q) % (1 << i))) >> i;
            exp_b = q[i] ? m : 8'h00;
            n_checks++;
            if (add_a !== exp_a[7:0] || add_b !== exp_b) begin
                n_errors++;
                $display("FAIL %s run%0d add_a/add_b got %h/%h want %h/%h",
                         tag, i, add_a, add_b, exp_a[7:0], exp_b);
            end
            n_checks++;
            if (product !== exp_product) begin
                n_errors++;
                $display("FAIL %s run%0d product_hold got %h want %h", tag, i, product, exp_product);
            end
        end
        step();
        start       = 1'b0;
        exp_product = 16'(int'(m) * int'(q));
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s done_cycle busy/done got %b/%b want 0/1", tag, busy, done);
        end
        n_checks++;
        if (product !== exp_product) begin
            n_errors++;
            $display("FAIL %s product got %h want %h", tag, product, exp_product);
        end
        n_checks++;
        if (add_a !== 8'h00 || add_b !== 8'h00) begin
            n_errors++;
            $display("FAIL %s done_adder got %h/%h want 00/00", tag, add_a, add_b);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || product !== exp_product ||
                add_a !== 8'h00 || add_b !== 8'h00) begin
                n_errors++;
                $display("FAIL %s idle%0d busy/done/product/a/b got %b/%b/%h/%h/%h want 0/0/%h/00/00",
                         tag, i, busy, done, product, add_a, add_b, exp_product);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b1;
        #2;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_state busy/done/product got %b/%b/%h want 0/0/0000", busy, done, product);
        end
        step();
        step();
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step();
        idle(2, "post_reset");
    endtask

    task automatic test_basic();
        run_one(8'd13, 8'd11, 1'b0, "m13q11");
        n_checks++;
        if (product !== 16'h008F) begin
            n_errors++;
            $display("FAIL m13q11_const got %h want 008f", product);
        end
        idle(2, "basic");
    endtask

    task automatic test_corners();
        run_one(8'd255, 8'd255, 1'b0, "m255q255");
        idle(1, "c1");
        run_one(8'd0, 8'd200, 1'b0, "m0q200");
        idle(1, "c2");
        run_one(8'd200, 8'd0, 1'b0, "m200q0");
        idle(1, "c3");
        run_one(8'd128, 8'd1, 1'b0, "m128q1");
        idle(1, "c4");
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            run_one(8'($urandom), 8'($urandom), 1'b0, "random");
            idle(int'($urandom_range(0, 2)), "rnd_gap");
        end
    endtask

    task automatic test_back_to_back();
        run_one(8'($urandom), 8'($urandom), 1'b1, "hold_start");
        run_one(8'd3, 8'd5, 1'b0, "b2b_m3q5");
        idle(2, "b2b");
    endtask

    task automatic test_reset_midrun();
        start  = 1'b1;
        mcand  = 8'd100;
        mplier = 8'd100;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2;
        resetn = 1'b0;
        #1;
        exp_product = 16'h0000;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 ||
            add_a !== 8'h00 || add_b !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset busy/done/product/a/b got %b/%b/%h/%h/%h want 0/0/0000/00/00",
                     busy, done, product, add_a, add_b);
        end
        @(posedge clk);
        #3;
        resetn = 1'b1;
        step();
        idle(12, "after_reset");
        run_one(8'd7, 8'd9, 1'b0, "m7q9");
        idle(1, "end");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
